// File: rtl/ped_crossing_ctrl_pkg.sv
// rtl/ped_crossing_ctrl_pkg.sv - shared types for the pedestrian crossing controller
//
// Purpose: FSM state enum, lamp encoding and small lamp-protocol helpers
// shared by ped_crossing_ctrl and its sub-modules.
// Ports: none (package).

package ped_crossing_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_REQ  = 3'd2,
    ST_HOLD = 3'd3,
    ST_WALK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LAMP_NONE   = 2'd0,
    LAMP_GREEN  = 2'd1,
    LAMP_YELLOW = 2'd2,
    LAMP_RED    = 2'd3
  } lamp_e;

  // Single-lamp code; callers must check lamp_multi() separately.
  function automatic lamp_e lamp_encode(input logic r, input logic y, input logic g);
    lamp_e l;
    if (g)      l = LAMP_GREEN;
    else if (y) l = LAMP_YELLOW;
    else if (r) l = LAMP_RED;
    else        l = LAMP_NONE;
    return l;
  endfunction

  function automatic logic lamp_multi(input logic r, input logic y, input logic g);
    return (r & y) | (r & g) | (y & g);
  endfunction

  // Only legal change of active lamp: green -> yellow -> red -> green.
  function automatic lamp_e lamp_successor(input lamp_e l);
    lamp_e n;
    case (l)
      LAMP_GREEN:  n = LAMP_YELLOW;
      LAMP_YELLOW: n = LAMP_RED;
      LAMP_RED:    n = LAMP_GREEN;
      default:     n = LAMP_NONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_btn_debounce.sv
// rtl/ped_crossing_ctrl_btn_debounce.sv - button synchronizer and debouncer
//
// Purpose: two-flop synchronizer followed by a stable-high counter; emits a
// one-cycle press pulse on the DEB_CYCLES-th consecutive high synced sample.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   button_i in  raw push-button, asynchronous to clk
//   press_o  out registered one-cycle press pulse

module btn_debounce
  import ped_crossing_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_i,
  output logic press_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Counter saturates at DEB_CYCLES so a long hold yields a single pulse;
  // only a low synced sample re-arms it.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(DEB_CYCLES)) begin
      cnt_d   = cnt_q + 1'b1;
      press_d = (cnt_q == CW'(DEB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing controller top
//
// Purpose: registers pedestrian requests, asks the intersection controller to
// shorten a long green, drives walk / don't-walk / countdown during red and
// flags lamp-protocol violations.
// Ports:
//   clk, rst_n              in  clock, asynchronous active-low reset
//   button_i                in  raw push-button
//   red_i/yellow_i/green_i  in  intersection lamp states
//   clock_i[7:0]            in  remaining-phase countdown
//   pass_request_o          out one-cycle shorten-green request
//   walk_o, dont_walk_o     out pedestrian lamps
//   wait_lamp_o             out request-registered indicator
//   countdown_o[7:0]        out pedestrian countdown display
//   seq_err_o               out sticky lamp-protocol violation

module ped_crossing_ctrl
  import ped_crossing_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int REQ_MIN_CLOCK = 10,
  parameter int FLASH_LAST    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_i,
  input  logic       red_i,
  input  logic       yellow_i,
  input  logic       green_i,
  input  logic [7:0] clock_i,
  output logic       pass_request_o,
  output logic       walk_o,
  output logic       dont_walk_o,
  output logic       wait_lamp_o,
  output logic [7:0] countdown_o,
  output logic       seq_err_o
);

  logic press;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .button_i (button_i),
    .press_o  (press)
  );

  state_e     state_q, state_d;
  logic       red_q;
  logic       primed_q;
  logic       pending_q, pending_d;
  logic       flash_q, flash_d;
  logic       pass_q, pass_d;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;
  logic       wait_q, wait_d;
  logic [7:0] countdown_q, countdown_d;
  lamp_e      last_lamp_q, last_lamp_d;
  logic       seen_q, seen_d;
  logic       seq_err_q, seq_err_d;

  // primed_q masks the first cycle after reset so a red already high at
  // release is not mistaken for a rising edge.
  logic red_rise, red_fall;
  assign red_rise = primed_q &  red_i & ~red_q;
  assign red_fall = primed_q & ~red_i &  red_q;

  lamp_e cur_lamp;
  logic  multi_lamp;
  logic  bad_order;
  logic  any_lamp;
  assign cur_lamp   = lamp_encode(red_i, yellow_i, green_i);
  assign multi_lamp = lamp_multi(red_i, yellow_i, green_i);
  assign any_lamp   = red_i | yellow_i | green_i;
  assign bad_order  = !multi_lamp && (cur_lamp != LAMP_NONE) && (last_lamp_q != LAMP_NONE) &&
                      (cur_lamp != last_lamp_q) && (cur_lamp != lamp_successor(last_lamp_q));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (press) state_d = red_rise ? ST_WALK : ST_WAIT;
      end
      ST_WAIT: begin
        if (red_rise)                                  state_d = ST_WALK;
        else if (green_i && clock_i > 8'(REQ_MIN_CLOCK)) state_d = ST_REQ;
        else if (green_i || yellow_i)                  state_d = ST_HOLD;
      end
      ST_REQ:  state_d = ST_HOLD;
      ST_HOLD: begin
        if (red_rise) state_d = ST_WALK;
      end
      ST_WALK: begin
        // A press in the same cycle as red falling still counts as pending.
        if (red_fall) begin
          state_d   = (pending_q || press) ? ST_WAIT : ST_IDLE;
          pending_d = 1'b0;
        end else if (press) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    pass_d      = (state_d == ST_REQ);
    wait_d      = (state_d == ST_WAIT) || (state_d == ST_REQ) || (state_d == ST_HOLD);
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    countdown_d = 8'd0;
    flash_d     = 1'b0;
    if (state_d == ST_WALK) begin
      countdown_d = clock_i;
      if (clock_i > 8'(FLASH_LAST)) begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end else begin
        flash_d     = 1'b1;
        dont_walk_d = flash_q ? ~dont_walk_q : 1'b1;
      end
    end
  end

  always_comb begin
    seq_err_d   = seq_err_q | multi_lamp | bad_order | (seen_q & ~any_lamp);
    last_lamp_d = (!multi_lamp && cur_lamp != LAMP_NONE) ? cur_lamp : last_lamp_q;
    seen_d      = seen_q | any_lamp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      red_q       <= 1'b0;
      primed_q    <= 1'b0;
      pending_q   <= 1'b0;
      flash_q     <= 1'b0;
      pass_q      <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      wait_q      <= 1'b0;
      countdown_q <= 8'd0;
      last_lamp_q <= LAMP_NONE;
      seen_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      red_q       <= red_i;
      primed_q    <= 1'b1;
      pending_q   <= pending_d;
      flash_q     <= flash_d;
      pass_q      <= pass_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      wait_q      <= wait_d;
      countdown_q <= countdown_d;
      last_lamp_q <= last_lamp_d;
      seen_q      <= seen_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign pass_request_o = pass_q;
  assign walk_o         = walk_q;
  assign dont_walk_o    = dont_walk_q;
  assign wait_lamp_o    = wait_q;
  assign countdown_o    = countdown_q;
  assign seq_err_o      = seq_err_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - self-checking bench for ped_crossing_ctrl

module tb_ped_crossing_ctrl;

  localparam int DEB = 4;
  localparam int MIN = 10;
  localparam int FL  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
  logic [7:0] clock_v = 8'd0;
  logic       pass_request, walk, dont_walk, wait_lamp, seq_err;
  logic [7:0] countdown;

  always #5 clk = ~clk;

  ped_crossing_ctrl #(.DEB_CYCLES(DEB), .REQ_MIN_CLOCK(MIN), .FLASH_LAST(FL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .button_i       (button),
    .red_i          (red),
    .yellow_i       (yellow),
    .green_i        (green),
    .clock_i        (clock_v),
    .pass_request_o (pass_request),
    .walk_o         (walk),
    .dont_walk_o    (dont_walk),
    .wait_lamp_o    (wait_lamp),
    .countdown_o    (countdown),
    .seq_err_o      (seq_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: button history, request/walk flags, lamp history.
  bit b_hist1, b_hist2;
  int run_len;
  bit press_ready;
  bit red_prev, primed;
  bit waiting, asked, walking, pending, pulse, flashing;
  bit e_walk, e_dw;
  int e_cd;
  bit seen, err;
  int last_lamp;

  task automatic model_reset();
    b_hist1 = 0; b_hist2 = 0; run_len = 0; press_ready = 0;
    red_prev = 0; primed = 0;
    waiting = 0; asked = 0; walking = 0; pending = 0; pulse = 0; flashing = 0;
    e_walk = 0; e_dw = 1; e_cd = 0;
    seen = 0; err = 0; last_lamp = 0;
  endtask

  task automatic model_edge();
    bit press, rise, fall, synced, prev_pulse;
    int n_on, cur;
    press = press_ready;
    synced = b_hist2;
    b_hist2 = b_hist1;
    b_hist1 = button;
    run_len = synced ? run_len + 1 : 0;
    press_ready = (run_len == DEB);

    rise = primed && red && !red_prev;
    fall = primed && !red && red_prev;
    red_prev = red;
    primed = 1;

    prev_pulse = pulse;
    pulse = 0;
    if (walking) begin
      if (fall) begin
        walking = 0; waiting = pending || press; asked = 0; pending = 0;
      end else if (press) pending = 1;
    end else if (waiting) begin
      if (rise && !prev_pulse) begin
        walking = 1; waiting = 0;
      end else if (!asked) begin
        if (green && clock_v > MIN) begin pulse = 1; asked = 1; end
        else if (green || yellow) asked = 1;
      end
    end else if (press) begin
      if (rise) walking = 1;
      else begin waiting = 1; asked = 0; end
    end

    if (walking) begin
      e_cd = clock_v;
      if (clock_v > FL) begin e_walk = 1; e_dw = 0; flashing = 0; end
      else begin e_walk = 0; e_dw = flashing ? !e_dw : 1; flashing = 1; end
    end else begin
      e_walk = 0; e_dw = 1; e_cd = 0; flashing = 0;
    end

    n_on = int'(red) + int'(yellow) + int'(green);
    cur = green ? 1 : yellow ? 2 : red ? 3 : 0;
    if (n_on > 1) err = 1;
    else if (n_on == 0) begin
      if (seen) err = 1;
    end else begin
      if (last_lamp != 0 && cur != last_lamp && cur != (last_lamp % 3) + 1) err = 1;
      last_lamp = cur;
    end
    if (n_on > 0) seen = 1;
  endtask

  task automatic compare_all();
    check("pass_request", pass_request, pulse);
    check("wait_lamp", wait_lamp, waiting);
    check("walk", walk, e_walk);
    check("dont_walk", dont_walk, e_dw);
    check("countdown", countdown, e_cd);
    check("seq_err", seq_err, err);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Legal traffic generator: green -> yellow -> red, clock = remaining cycles.
  int g_phase = 2;
  int g_left  = 0;
  int b_left  = 0;

  task automatic gen_lamps();
    if (g_left == 0) begin
      g_phase = (g_phase + 1) % 3;
      g_left = (g_phase == 0) ? $urandom_range(5, 45) : (g_phase == 1) ? 3 : $urandom_range(6, 14);
    end
    green = (g_phase == 0); yellow = (g_phase == 1); red = (g_phase == 2);
    clock_v = 8'(g_left);
    g_left--;
  endtask

  task automatic gen_button();
    if (b_left > 0) begin button = 1; b_left--; end
    else begin
      button = 0;
      if ($urandom_range(0, 15) == 0) b_left = $urandom_range(1, 12);
    end
  endtask

  task automatic set_lamps(input bit r, input bit y, input bit g, input int cv);
    red = r; yellow = y; green = g; clock_v = 8'(cv);
  endtask

  initial begin
    int found, pulses;
    model_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1;

    for (int i = 0; i < 4000; i++) begin
      gen_lamps(); gen_button(); cycle();
    end

    // Reset asserted in the pass-request cycle aborts immediately.
    found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      gen_lamps(); gen_button(); cycle();
      if (pulse) found = 1;
    end
    check("req_reached", found, 1);
    if (found != 0) begin
      rst_n = 0;
      #1;
      model_reset();
      compare_all();
      check("abort_pass_request", pass_request, 0);
      check("abort_dont_walk", dont_walk, 1);
      button = 0; b_left = 0;
      gen_lamps(); cycle();
      rst_n = 1;
      for (int i = 0; i < 30; i++) begin gen_lamps(); cycle(); end
    end

    // Short glitch then a real press on a long steady green.
    rst_n = 0; button = 0; set_lamps(0, 0, 1, 40); model_reset(); cycle();
    rst_n = 1;
    button = 1; repeat (3) cycle();
    button = 0; repeat (10) cycle();
    check("glitch_no_wait", wait_lamp, 0);
    pulses = 0;
    button = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) button = 0;
      cycle();
      if (pass_request) pulses++;
    end
    check("single_pulse", pulses, 1);
    check("wait_held", wait_lamp, 1);

    // Two lamps at once: sticky error after lamps recover.
    set_lamps(1, 0, 1, 5); cycle();
    set_lamps(0, 0, 1, 5); repeat (3) cycle();
    check("seq_err_multi", seq_err, 1);

    // green straight to red is illegal.
    rst_n = 0; set_lamps(0, 0, 1, 20); model_reset(); cycle();
    rst_n = 1;
    repeat (3) cycle();
    check("seq_err_clear", seq_err, 0);
    set_lamps(1, 0, 0, 9); cycle();
    set_lamps(1, 0, 0, 8); cycle();
    check("seq_err_order", seq_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the consecutive stable-high cycles needed to accept a button press.
REQ-002 Parameter REQ_MIN_CLOCK, default 10, SHALL set the green clock value strictly above which a pass request is issued.
REQ-003 Parameter FLASH_LAST, default 3, SHALL set the red clock value at or below which the walk phase flashes.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 button  in  1  raw pedestrian push-button, asynchronous to clk.
REQ-007 red, yellow, green  in  1 each  lamp states from the intersection controller.
REQ-008 clock  in  8  remaining-phase countdown from the intersection controller.
REQ-009 pass_request  out  1  single-cycle request to the intersection controller to shorten green.
REQ-010 walk  out  1  walk lamp.
REQ-011 dont_walk  out  1  don't-walk lamp (steady or flashing).
REQ-012 wait_lamp  out  1  "request registered" indicator.
REQ-013 countdown  out  8  pedestrian countdown display.
REQ-014 seq_err  out  1  sticky lamp-protocol violation flag.

Function
REQ-015 button SHALL pass a 2-flop synchronizer, then a debouncer; press event = one-cycle pulse when the synced input has been high DEB_CYCLES consecutive cycles after being low.
REQ-016 FSM states SHALL be IDLE, WAIT, REQ, HOLD, WALK; all outputs registered.
REQ-017 IDLE: press event -> WAIT; otherwise stay.
REQ-018 WAIT: wait_lamp=1; red rising edge -> WALK; else green=1 and clock > REQ_MIN_CLOCK -> REQ; else green with clock <= REQ_MIN_CLOCK, yellow -> HOLD.
REQ-019 REQ: pass_request=1 for exactly this one cycle, wait_lamp=1; unconditionally -> HOLD next cycle.
REQ-020 HOLD: wait_lamp=1, pass_request=0; red rising edge -> WALK.
REQ-021 WALK: wait_lamp=0; countdown=clock input each cycle; if clock > FLASH_LAST walk=1, dont_walk=0; else walk=0, dont_walk toggles every cycle starting at 1.
REQ-022 WALK exit on red falling edge: -> WAIT if a press event occurred during WALK (pending flag), else IDLE; dont_walk=1, countdown=0.
REQ-023 Outside WALK: walk=0, dont_walk=1, countdown=0.
REQ-024 Press events in WAIT, REQ, HOLD SHALL be ignored (no second request).
REQ-025 Press event coincident with red rising edge in IDLE SHALL enter WALK directly.
REQ-026 Edge detection SHALL use a registered copy of red; red previously high at reset-release SHALL NOT count as a rising edge.
REQ-027 seq_err SHALL set when more than one of red/yellow/green is high.
REQ-028 seq_err SHALL set on an illegal change of active lamp; legal order green->yellow->red->green only.
REQ-029 All lamps low SHALL be legal until the first lamp is seen after reset; afterwards it SHALL set seq_err.
REQ-030 seq_err SHALL stay set until reset; FSM continues operating when set.

Reset
REQ-031 During reset: pass_request=0, walk=0, dont_walk=1, wait_lamp=0, countdown=0, seq_err=0, FSM=IDLE, synchronizer/debouncer/pending/lamp history cleared.
REQ-032 Reset mid-WALK or mid-REQ SHALL abort immediately; no pass_request pulse after release.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and the lamp encoding constants (NONE, GREEN, YELLOW, RED).
REQ-034 Synchronizer plus debouncer SHALL be sub-module btn_debounce (parameter DEB_CYCLES, outputs press pulse).

Verification
REQ-035 Press held 10 cycles while green clock=40 -> pass_request single pulse ~7 cycles later (2 sync + 4 deb + FSM), wait_lamp=1 until red.
REQ-036 Press glitches of 3 cycles (DEB_CYCLES=4) -> no press event, FSM remains IDLE.
REQ-037 Press while green clock=8 -> no pass_request; HOLD; walk=1 cycle after red rises.
REQ-038 Red phase clock 10..1 in WALK -> countdown tracks 10..1; walk=1 for clock 10..4; dont_walk toggles 1,0,1 for clock 3..1; exit at red fall.
REQ-039 green and red high together -> seq_err=1 next cycle, stays after lamps recover; green->red directly -> seq_err=1.
REQ-040 rst_n low during REQ cycle -> pass_request=0 immediately, all outputs at reset values.
